// File: rtl/gen3_rx_descrambler.sv
// Per-lane 128b/130b receive descrambler: tracks block framing, classifies ordered sets,
// and removes the Gen3 scrambler keystream with one cycle of registered latency.
module gen3_rx_descrambler #(
   parameter int BLOCK_SYMBOLS = 16,
   parameter int SEED_WIDTH    = 24
) (
   input  logic                  pclk,
   input  logic                  reset_n,
   input  logic [SEED_WIDTH-1:0] seedValue,
   input  logic                  scrambler_reset,
   input  logic [7:0]            data_in,
   input  logic                  data_valid,
   input  logic                  block_start,
   input  logic [1:0]            sync_header,
   output logic [7:0]            data_out,
   output logic                  data_out_valid,
   output logic                  block_start_out,
   output logic [1:0]            sync_header_out,
   output logic                  os_block,
   output logic                  skp_block,
   output logic                  eieos_detected,
   output logic                  blk_err
);

   // state    | meaning
   // S_IDLE   | between blocks, waiting for block_start
   // S_DATA   | data block, every byte descrambled
   // S_OS     | ordered set, LFSR advances, only TS bytes 1..13 descrambled
   // S_SKP    | SKP ordered set, raw bytes, LFSR frozen
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_OS, S_SKP} state_t;

   localparam logic [3:0]  LAST_IDX = 4'(BLOCK_SYMBOLS - 1);
   localparam logic [22:0] TAPS     = 23'h210124;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [22:0] r_lfsr;
   logic        r_ts;
   logic        r_eieos;
   logic [1:0]  r_hdr;

   state_t      w_cur_state, w_nxt_state;
   logic [3:0]  w_idx, w_nxt_cnt;
   logic [22:0] w_nxt_lfsr, w_lfsr_adv;
   logic [7:0]  w_ks;
   logic        w_cur_ts, w_cur_eieos, w_nxt_ts, w_nxt_eieos;
   logic [1:0]  w_cur_hdr, w_nxt_hdr;
   logic        w_start, w_err, w_active, w_last, w_descr;
   logic [22:0] w_seed;
   logic        w_unused_seed;

   logic [7:0]  w_dout;
   logic        w_ovalid, w_bso, w_os, w_skp, w_eie, w_berr;
   logic [1:0]  w_hdr_o;

   assign w_seed        = seedValue[22:0];
   assign w_unused_seed = ^seedValue[SEED_WIDTH-1:23];

   // Galois form: serial output is bit 22, fed back into the tap positions
   function automatic logic [30:0] lfsr_step8(input logic [22:0] s_in);
      logic [22:0] s;
      logic [7:0]  ks;
      s  = s_in;
      ks = 8'h00;
      for (int b = 0; b < 8; b++) begin
         ks[b] = s[22];
         s     = {s[21:0], s[22]} ^ ({23{s[22]}} & TAPS);
      end
      return {ks, s};
   endfunction

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_lfsr  <= w_seed;
         r_ts    <= 1'b0;
         r_eieos <= 1'b0;
         r_hdr   <= 2'b00;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_lfsr  <= w_nxt_lfsr;
         r_ts    <= w_nxt_ts;
         r_eieos <= w_nxt_eieos;
         r_hdr   <= w_nxt_hdr;
      end
   end

   always_comb begin
      w_start     = data_valid & block_start;
      w_cur_state = r_state;
      w_cur_ts    = r_ts;
      w_cur_eieos = r_eieos;
      w_cur_hdr   = r_hdr;
      w_idx       = r_cnt;
      w_err       = 1'b0;
      if (w_start) begin
         w_idx       = 4'd0;
         w_cur_hdr   = sync_header;
         w_cur_ts    = 1'b0;
         w_cur_eieos = 1'b0;
         w_err       = (r_cnt != 4'd0) || (sync_header == 2'b00) || (sync_header == 2'b11);
         if (sync_header == 2'b10) begin
            w_cur_state = S_DATA;
         end else if (sync_header == 2'b01) begin
            w_cur_state = S_OS;
            case (data_in)
               8'hAA:        w_cur_state = S_SKP;
               8'h00:        w_cur_eieos = 1'b1;
               8'h1E, 8'h2D: w_cur_ts    = 1'b1;
               default:      ;
            endcase
         end else begin
            w_cur_state = S_IDLE;
         end
      end
      w_active = data_valid && (w_cur_state != S_IDLE);
      w_last   = (w_idx == LAST_IDX);
      {w_ks, w_lfsr_adv} = lfsr_step8(r_lfsr);

      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_lfsr  = r_lfsr;
      w_nxt_ts    = r_ts;
      w_nxt_eieos = r_eieos;
      w_nxt_hdr   = r_hdr;
      if (scrambler_reset) begin
         w_nxt_state = S_IDLE;
         w_nxt_cnt   = 4'd0;
         w_nxt_lfsr  = w_seed;
         w_nxt_ts    = 1'b0;
         w_nxt_eieos = 1'b0;
      end else if (data_valid) begin
         w_nxt_ts    = w_cur_ts;
         w_nxt_eieos = w_cur_eieos;
         w_nxt_hdr   = w_cur_hdr;
         if (!w_active) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = 4'd0;
         end else begin
            if (w_cur_state == S_DATA || w_cur_state == S_OS)
               w_nxt_lfsr = w_lfsr_adv;
            if (w_last) begin
               w_nxt_state = S_IDLE;
               w_nxt_cnt   = 4'd0;
               if (w_cur_eieos)
                  w_nxt_lfsr = w_seed;
            end else begin
               w_nxt_state = w_cur_state;
               w_nxt_cnt   = w_idx + 4'd1;
            end
         end
      end
   end

   always_comb begin
      w_descr  = (w_cur_state == S_DATA) ||
                 ((w_cur_state == S_OS) && w_cur_ts && (w_idx != 4'd0) && (w_idx <= 4'd13));
      w_ovalid = w_active && !scrambler_reset;
      w_dout   = 8'h00;
      if (w_ovalid)
         w_dout = w_descr ? (data_in ^ w_ks) : data_in;
      w_bso   = w_ovalid && (w_idx == 4'd0);
      w_hdr_o = w_ovalid ? w_cur_hdr : 2'b00;
      w_os    = w_ovalid && ((w_cur_state == S_OS) || (w_cur_state == S_SKP));
      w_skp   = w_ovalid && (w_cur_state == S_SKP);
      w_eie   = w_ovalid && w_last && w_cur_eieos;
      w_berr  = w_err && !scrambler_reset;
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         data_out        <= 8'h00;
         data_out_valid  <= 1'b0;
         block_start_out <= 1'b0;
         sync_header_out <= 2'b00;
         os_block        <= 1'b0;
         skp_block       <= 1'b0;
         eieos_detected  <= 1'b0;
         blk_err         <= 1'b0;
      end else begin
         data_out        <= w_dout;
         data_out_valid  <= w_ovalid;
         block_start_out <= w_bso;
         sync_header_out <= w_hdr_o;
         os_block        <= w_os;
         skp_block       <= w_skp;
         eieos_detected  <= w_eie;
         blk_err         <= w_berr;
      end
   end

endmodule

// File: doc/gen3_rx_descrambler.md
Name: gen3_rx_descrambler

Overview:
- Per-lane Gen3 (128b/130b) receive descrambler; mirror of the Gen3 transmit scrambler.
- Sits after block alignment, before the lane deskew/ordered-set decoder.
- Consumes one byte per pclk with block framing.
- Descrambles data blocks and ordered-set blocks per Gen3 rules, tracks block position, and reseeds on EIEOS.

Parameters:
BLOCK_SYMBOLS, 16, bytes per 128b/130b block; fixed at 16. SKP OS supported only at 16 symbols.
SEED_WIDTH, 24, seed port width; only bits [22:0] are used.

Ports:
pclk  input  1  clock
reset_n  input  1  asynchronous active-low reset
seedValue  input  SEED_WIDTH  lane seed; [22:0] loaded into LFSR
scrambler_reset  input  1  synchronous reload of seed and return to IDLE
data_in  input  8  received byte
data_valid  input  1  data_in valid this cycle
block_start  input  1  with data_valid: data_in is byte 0 of a block
sync_header  input  2  sampled when block_start; 2'b10 data, 2'b01 ordered set
data_out  output  8  descrambled or bypassed byte
data_out_valid  output  1  data_out valid
block_start_out  output  1  data_out is byte 0
sync_header_out  output  2  header of current output block
os_block  output  1  current output block is an ordered set
skp_block  output  1  current output block is SKP OS
eieos_detected  output  1  one-cycle pulse with byte 15 of an EIEOS
blk_err  output  1  one-cycle pulse on framing error

Behaviour:
- Reset (reset_n low, async):
  - LFSR = seedValue[22:0]; state IDLE; byte counter 0.
  - All outputs 0.
- LFSR:
  - 23-bit, polynomial x^23+x^21+x^16+x^8+x^5+x^2+1.
  - Next-state and keystream mapping are identical to the Gen3 transmit scrambler: 8 serial steps per advance, keystream bit i = serial output at step i.
- Latency: exactly 1 cycle, data_in -> data_out; all outputs registered.
- States: IDLE, DATA_BLK, OS_BLK, SKP_BLK. Byte counter 0..15.
  - Only cycles with data_valid=1 change state, counter or LFSR.
  - Cycles with data_valid=0 hold all state; data_out_valid=0 on the next cycle.
- IDLE:
  - Ignore bytes until block_start.
  - On block_start, sync_header 10 -> DATA_BLK. 01 -> inspect byte 0:
    - AA -> SKP_BLK
    - 00 -> OS_BLK, EIEOS flag set
    - 1E or 2D -> OS_BLK, TS flag set
    - other -> OS_BLK
  - sync_header 00 or 11: blk_err pulse; block dropped (no output, no LFSR advance); stay IDLE.
- DATA_BLK: every byte is data_in XOR keystream; LFSR advances per byte.
- OS_BLK:
  - LFSR advances on every byte.
  - Output descrambled only for TS flag and byte index 1..13; all other bytes pass raw.
- SKP_BLK: bytes pass raw; LFSR does not advance.
- Sync header never advances the LFSR.
- Byte 15: counter wraps to 0, return to IDLE.
  - If the EIEOS flag is set: LFSR reloads seedValue[22:0] (takes effect for the next block's byte 0) and eieos_detected pulses with byte 15 output.
- block_start while counter != 0:
  - blk_err pulse; current block abandoned.
  - New block processed from this byte with the same header rules.
  - LFSR not reseeded.
- scrambler_reset=1 (synchronous):
  - LFSR reload, state IDLE, counter 0.
  - Input byte that cycle ignored; outputs 0 next cycle.
  - Has priority over all other events.
- block_start_out, sync_header_out, os_block and skp_block are aligned with data_out; flags are held for all 16 output bytes.

Test Plan:
1. Loopback: transmit scrambler (seed 24'h1DBFBC) scrambles 4 data blocks of 0x00..0x0F; feed to DUT with the same seed -> data_out = 0x00..0x0F each block, 1-cycle latency, blk_err=0.
2. SKP: data block, SKP block (16×AA, header 01), data block -> SKP bytes output AA unchanged; third block descrambles correctly, proving no LFSR advance during SKP.
3. TS1 block (byte0 1E) from scrambler -> byte 0, 14, 15 raw; bytes 1..13 match original; following data block correct.
4. EIEOS (00/FF pattern) after 3 data blocks -> eieos_detected pulse on byte 15; next data block descrambles correctly from the fresh seed.
5. Header 2'b11 block, then block_start at counter=7 -> blk_err pulses twice; bad block produces no data_out_valid; resynced block output correct.
6. data_valid gaps every other cycle plus reset_n low mid-block -> gaps hold state; after reset all outputs 0 and the next seed-aligned block decodes correctly.
